// File: rtl/dsp_mem_pkg.sv
// Shared types for the dsp_core memory bank: default widths, signed word and host write entry.
package dsp_mem_pkg;

    localparam int DATA_W_DEF = 36;
    localparam int ADDR_W_DEF = 10;

    typedef logic signed [DATA_W_DEF-1:0] word_t;

    typedef struct packed {
        logic [ADDR_W_DEF-1:0] addr;
        word_t                 data;
    } host_wr_t;

endpackage

// File: rtl/dsp_mem_host_fifo.sv
// Synchronous FIFO buffering host write entries until an idle RAM write slot drains them.
module dsp_mem_host_fifo
    import dsp_mem_pkg::*;
#(
    parameter int  DEPTH = 4,
    parameter type T     = host_wr_t
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   i_push,
    input  T                       i_din,
    input  logic                   i_pop,
    output T                       o_dout,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    T                 r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [LVL_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == LVL_W'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_level = r_count;
    assign o_dout  = r_mem[r_rd_ptr];
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= r_count + LVL_W'(w_push) - LVL_W'(w_pop);
        end
    end

    // Storage is not reset; pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_din;
    end

endmodule

// File: rtl/dsp_mem_bank.sv
// Word memory behind one dsp_core bus: fixed-latency read, core write, buffered host load port.
// Optional even parity per word when DSP_MEM_PARITY_EN is defined.
module dsp_mem_bank
    import dsp_mem_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int RD_LAT      = 1,
    parameter int HFIFO_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         rd_en,
    input  logic [ADDR_W-1:0]            rd_addr,
    output logic signed [DATA_W-1:0]     rd_data,
    output logic                         rd_valid,
    input  logic                         wr_en,
    input  logic [ADDR_W-1:0]            wr_addr,
    input  logic signed [DATA_W-1:0]     wr_data,
    input  logic                         host_valid,
    input  logic [ADDR_W-1:0]            host_addr,
    input  logic [DATA_W-1:0]            host_data,
    output logic                         host_ready,
    output logic [$clog2(HFIFO_DEPTH):0] hfifo_level,
    output logic                         parity_err
);

`ifdef DSP_MEM_PARITY_EN
    localparam int MEM_W = DATA_W + 1;
`else
    localparam int MEM_W = DATA_W;
`endif
    localparam int DEPTH = 2 ** ADDR_W;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } ent_t;

    logic [MEM_W-1:0]  r_mem [DEPTH];
    ent_t              w_host_in;
    ent_t              w_head;
    logic              w_full;
    logic              w_empty;
    logic              w_pop;
    logic              w_we;
    logic [ADDR_W-1:0] w_waddr;
    logic [DATA_W-1:0] w_wdata;
    logic [MEM_W-1:0]  w_wword;
    logic [MEM_W-1:0]  w_rword;
    logic [DATA_W-1:0] w_rd_data;
    logic              w_rd_byp;
    logic              w_rd_perr;

    // Core write owns the slot; the host head entry only drains when the core is idle.
    assign host_ready = reset_n && !w_full;
    assign w_host_in  = '{addr: host_addr, data: host_data};
    assign w_pop      = reset_n && !wr_en && !w_empty;
    assign w_we       = reset_n && (wr_en || !w_empty);
    assign w_waddr    = wr_en ? wr_addr : w_head.addr;
    assign w_wdata    = wr_en ? wr_data : w_head.data;

`ifdef DSP_MEM_PARITY_EN
    assign w_wword   = {^w_wdata, w_wdata};
    assign w_rd_perr = ^w_rword;
`else
    assign w_wword   = w_wdata;
    assign w_rd_perr = 1'b0;
`endif

    assign w_rword   = r_mem[rd_addr];
    assign w_rd_byp  = w_we && (w_waddr == rd_addr);
    assign w_rd_data = w_rd_byp ? w_wdata : w_rword[DATA_W-1:0];

    always_ff @(posedge clk) begin
        if (w_we) r_mem[w_waddr] <= w_wword;
    end

    dsp_mem_host_fifo #(
        .DEPTH (HFIFO_DEPTH),
        .T     (ent_t)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .i_push  (host_valid && host_ready),
        .i_din   (w_host_in),
        .i_pop   (w_pop),
        .o_dout  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (hfifo_level)
    );

    generate
        if (RD_LAT == 1) begin : g_lat1
            always_ff @(posedge clk) begin
                if (!reset_n) begin
                    rd_valid   <= 1'b0;
                    rd_data    <= '0;
                    parity_err <= 1'b0;
                end else begin
                    rd_valid   <= rd_en;
                    parity_err <= rd_en && !w_rd_byp && w_rd_perr;
                    if (rd_en) rd_data <= w_rd_data;
                end
            end
        end else begin : g_lat2
            logic              r_s1_valid;
            logic              r_s1_perr;
            logic [ADDR_W-1:0] r_s1_addr;
            logic [DATA_W-1:0] r_s1_data;
            logic              w_s2_byp;

            // A commit landing one cycle after the read still forwards its data.
            assign w_s2_byp = w_we && (w_waddr == r_s1_addr);

            always_ff @(posedge clk) begin
                if (!reset_n) begin
                    r_s1_valid <= 1'b0;
                    r_s1_perr  <= 1'b0;
                    rd_valid   <= 1'b0;
                    rd_data    <= '0;
                    parity_err <= 1'b0;
                end else begin
                    r_s1_valid <= rd_en;
                    rd_valid   <= r_s1_valid;
                    parity_err <= r_s1_valid && r_s1_perr && !w_s2_byp;
                    if (rd_en) begin
                        r_s1_addr <= rd_addr;
                        r_s1_data <= w_rd_data;
                        r_s1_perr <= !w_rd_byp && w_rd_perr;
                    end
                    if (r_s1_valid) rd_data <= w_s2_byp ? w_wdata : r_s1_data;
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_dsp_mem_bank.sv
// Bench for dsp_mem_bank: RD_LAT=1 and RD_LAT=2 instances share stimulus; scoreboard queues vs memory model.
module tb_dsp_mem_bank;

    localparam int DW    = 36;
    localparam int AW    = 10;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          rd_en = 1'b0;
    logic          wr_en = 1'b0;
    logic          host_valid = 1'b0;
    logic [AW-1:0] rd_addr = '0;
    logic [AW-1:0] wr_addr = '0;
    logic [AW-1:0] host_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic [DW-1:0] host_data = '0;

    logic signed [DW-1:0] rd_data1, rd_data2;
    logic                 rd_valid1, rd_valid2;
    logic                 host_ready1, host_ready2;
    logic                 perr1, perr2;
    logic [2:0]           lvl1, lvl2;

    int total = 0;
    int bad   = 0;

    typedef struct { logic [DW-1:0] data; bit known; bit perr; } rd_exp_t;
    typedef struct { int level; bit ready; bit was_rst; }        st_exp_t;
    typedef struct { logic [AW-1:0] addr; logic [DW-1:0] data; } hw_t;

    rd_exp_t       q1[$];
    rd_exp_t       q2[$];
    st_exp_t       sq[$];
    hw_t           hq[$];
    logic [DW-1:0] mm [int];
    bit            bad_par [int];
    bit            pend2_v = 1'b0;
    logic [AW-1:0] pend2_a = '0;
    bit            prev_rst_n = 1'b0;
    logic [DW-1:0] last_d [1:2];
    bit            last_k [1:2];

    initial forever #5 clk = ~clk;

    dsp_mem_bank #(.DATA_W(DW), .ADDR_W(AW), .RD_LAT(1), .HFIFO_DEPTH(DEPTH)) dut1 (
        .clk(clk), .reset_n(reset_n), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data1), .rd_valid(rd_valid1), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .host_valid(host_valid), .host_addr(host_addr),
        .host_data(host_data), .host_ready(host_ready1), .hfifo_level(lvl1),
        .parity_err(perr1));

    dsp_mem_bank #(.DATA_W(DW), .ADDR_W(AW), .RD_LAT(2), .HFIFO_DEPTH(DEPTH)) dut2 (
        .clk(clk), .reset_n(reset_n), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data2), .rd_valid(rd_valid2), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .host_valid(host_valid), .host_addr(host_addr),
        .host_data(host_data), .host_ready(host_ready2), .hfifo_level(lvl2),
        .parity_err(perr2));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic rd_exp_t lookup(input logic [AW-1:0] a);
        rd_exp_t e;
        e.known = mm.exists(int'(a));
        e.data  = e.known ? mm[int'(a)] : '0;
        e.perr  = bad_par.exists(int'(a));
        return e;
    endfunction

    function automatic void commit(input logic [AW-1:0] a, input logic [DW-1:0] d);
        mm[int'(a)] = d;
        bad_par.delete(int'(a));
    endfunction

    // One clock of stimulus. The model treats a read as returning the memory
    // contents at the end of cycle N+RD_LAT-1, which is what write-first forwarding means.
    task automatic cyc(input bit rst_n, input bit re, input logic [AW-1:0] ra,
                       input bit we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                       input bit hv, input logic [AW-1:0] ha, input logic [DW-1:0] hd);
        st_exp_t s;
        hw_t     h;
        bit      push_ok;
        @(posedge clk);
        #1;
        reset_n = rst_n; rd_en = re; rd_addr = ra;
        wr_en = we; wr_addr = wa; wr_data = wd;
        host_valid = hv; host_addr = ha; host_data = hd;
        s.level   = hq.size();
        s.ready   = rst_n && (hq.size() < DEPTH);
        s.was_rst = !prev_rst_n;
        sq.push_back(s);
        prev_rst_n = rst_n;
        if (!rst_n) begin
            hq.delete();
            pend2_v = 1'b0;
        end else begin
            push_ok = hv && (hq.size() < DEPTH);
            if (we) commit(wa, wd);
            else if (hq.size() > 0) begin
                h = hq.pop_front();
                commit(h.addr, h.data);
            end
            if (push_ok) begin
                h.addr = ha; h.data = hd;
                hq.push_back(h);
            end
            if (pend2_v) q2.push_back(lookup(pend2_a));
            pend2_v = re;
            pend2_a = ra;
            if (re) q1.push_back(lookup(ra));
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1, 0, '0, 0, '0, '0, 0, '0, '0);
    endtask

    task automatic rd(input logic [AW-1:0] a);
        cyc(1, 1, a, 0, '0, '0, 0, '0, '0);
    endtask

    task automatic check_rd(input int lat, input bit was_rst, input logic v,
                            input logic [DW-1:0] d, input logic pe);
        rd_exp_t e;
        bit      have;
        if (was_rst) begin
            chk($sformatf("rst_valid_lat%0d", lat), 64'(v), 64'd0);
            chk($sformatf("rst_data_lat%0d", lat), 64'(d), 64'd0);
            last_d[lat] = '0;
            last_k[lat] = 1'b1;
        end else if (v) begin
            have = (lat == 1) ? (q1.size() > 0) : (q2.size() > 0);
            total++;
            if (!have) begin
                bad++;
                $display("FAIL unexpected_valid_lat%0d: got rd_valid=1 want no read pending", lat);
            end else begin
                if (lat == 1) e = q1.pop_front();
                else          e = q2.pop_front();
                if (e.known) chk($sformatf("rd_data_lat%0d", lat), 64'(d), 64'(e.data));
                chk($sformatf("parity_err_lat%0d", lat), 64'(pe), 64'(e.perr));
                last_d[lat] = e.data;
                last_k[lat] = e.known;
            end
        end else begin
            if (last_k[lat]) chk($sformatf("hold_lat%0d", lat), 64'(d), 64'(last_d[lat]));
            chk($sformatf("perr_idle_lat%0d", lat), 64'(pe), 64'd0);
        end
    endtask

    always @(negedge clk) begin
        st_exp_t s;
        if (sq.size() > 0) begin
            s = sq.pop_front();
            chk("level_lat1", 64'(lvl1), 64'(s.level));
            chk("level_lat2", 64'(lvl2), 64'(s.level));
            chk("ready_lat1", 64'(host_ready1), 64'(s.ready));
            chk("ready_lat2", 64'(host_ready2), 64'(s.ready));
            check_rd(1, s.was_rst, rd_valid1, rd_data1, perr1);
            check_rd(2, s.was_rst, rd_valid2, rd_data2, perr2);
        end
    end

    function automatic logic [DW-1:0] rnd_word();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        return r[DW-1:0];
    endfunction

    initial begin
        last_d[1] = '0; last_d[2] = '0;
        last_k[1] = 1'b0; last_k[2] = 1'b0;

        // Reads and host offers during reset must have no effect.
        repeat (3) cyc(0, 1, '0, 1, 10'h001, 36'h1, 1, 10'h002, 36'h2);
        rd(10'h000);
        idle(3);

        // Same-cycle write/read bypass, and the one-cycle-late forward for RD_LAT=2.
        cyc(1, 1, 10'h3FF, 1, 10'h3FF, 36'h8_0000_0001, 0, '0, '0);
        rd(10'h3FE);
        cyc(1, 0, '0, 1, 10'h3FE, 36'h1_2345_6789, 0, '0, '0);
        rd(10'h3FF);
        rd(10'h3FE);
        idle(2);

        // Fill the host FIFO under continuous core writes, then let it drain.
        for (int i = 0; i < 4; i++)
            cyc(1, 0, '0, 1, 10'h3F0, DW'(i), 1, AW'(10'h010 + i), DW'(i + 1));
        cyc(1, 0, '0, 1, 10'h3F0, 36'h55, 0, '0, '0);
        idle(5);
        for (int i = 0; i < 4; i++) rd(AW'(10'h010 + i));
        idle(3);

        // Offer on a full FIFO in the same cycle it drains: refused, then taken.
        for (int i = 0; i < 4; i++)
            cyc(1, 0, '0, 1, 10'h3F1, DW'(i), 1, AW'(10'h030 + i), DW'(36'hA0 + i));
        cyc(1, 0, '0, 0, '0, '0, 1, 10'h034, 36'hA4);
        cyc(1, 0, '0, 0, '0, '0, 1, 10'h034, 36'hA4);
        idle(6);
        for (int i = 0; i < 5; i++) rd(AW'(10'h030 + i));
        idle(3);

        // Reset with three pending host entries and reads in flight.
        for (int i = 0; i < 3; i++) cyc(1, 0, '0, 1, AW'(10'h020 + i), DW'(36'h77700 + i), 0, '0, '0);
        cyc(1, 0, '0, 1, 10'h3F2, 36'h0, 1, 10'h020, 36'hDEAD0);
        cyc(1, 1, 10'h020, 1, 10'h3F2, 36'h0, 1, 10'h021, 36'hDEAD1);
        cyc(1, 1, 10'h021, 1, 10'h3F2, 36'h0, 1, 10'h022, 36'hDEAD2);
        cyc(0, 0, '0, 0, '0, '0, 0, '0, '0);
        cyc(0, 0, '0, 0, '0, '0, 0, '0, '0);
        idle(3);
        for (int i = 0; i < 3; i++) rd(AW'(10'h020 + i));
        idle(3);

        // Parity: corrupt one stored bit behind the design's back.
        cyc(1, 0, '0, 1, 10'h055, 36'h3_0F0F_0F0F, 0, '0, '0);
        idle(2);
`ifdef DSP_MEM_PARITY_EN
        dut1.r_mem[10'h055] = dut1.r_mem[10'h055] ^ 37'd1;
        dut2.r_mem[10'h055] = dut2.r_mem[10'h055] ^ 37'd1;
        mm[int'(10'h055)] = mm[int'(10'h055)] ^ 36'd1;
        bad_par[int'(10'h055)] = 1'b1;
`endif
        rd(10'h055);
        idle(3);

        // Randomized traffic over a small address window so reads hit recent writes.
        for (int n = 0; n < 800; n++) begin
            cyc(($urandom_range(0, 149) != 0),
                1'($urandom_range(0, 1)), AW'(10'h3F0 + $urandom_range(0, 15)),
                ($urandom_range(0, 2) == 0), AW'(10'h3F0 + $urandom_range(0, 15)), rnd_word(),
                1'($urandom_range(0, 1)), AW'(10'h3F0 + $urandom_range(0, 15)), rnd_word());
        end
        idle(10);
        @(negedge clk);
        #1;
        chk("lat1_reads_outstanding", 64'(q1.size()), 64'd0);
        chk("lat2_reads_outstanding", 64'(q2.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
